// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for rom_port_arbiter.
//   owner_e        - owner of the request accepted last cycle
//   pend_t         - pending-response record (owner + oob + err flags)
//   NOP_INST       - instruction returned for out-of-range fetches
//   DATA_OOB_VALUE - word returned for out-of-range data reads
package rom_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   oob;
        logic   err;
    } pend_t;

    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam logic [31:0] DATA_OOB_VALUE = 32'h0000_0000;
    localparam int          STREAK_W       = 4;

    // Word index (byte address >> 2) compared against the ROM depth.
    function automatic logic word_in_range(input logic [29:0] word, input int depth);
        return {2'b00, word} < 32'(depth);
    endfunction

endpackage

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a single-port synchronous-read ROM between the
// instruction-fetch port (i_*) and the load unit's read-only path (d_*).
//   clk, rst_n               - clock, async active-low reset
//   i_req_valid/ready/addr   - fetch request handshake, byte address
//   i_rsp_valid/data         - fetch response, one cycle after accept
//   d_req_valid/ready/addr   - data request handshake, byte address
//   d_rsp_valid/data/err     - data response, err flags misalignment
//   rom_en/rom_addr          - ROM read strobe and word address
//   rom_rdata                - ROM data, valid the cycle after rom_en
// Data wins arbitration, except that a waiting fetch is forced through once
// data has been granted MAX_DATA_STREAK times in a row.
import rom_arb_pkg::*;

module rom_port_arbiter #(
    parameter int ROM_DEPTH       = 16384,
    parameter int ADDR_W          = 14,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [31:0]       i_req_addr,
    output logic              i_rsp_valid,
    output logic [31:0]       i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [31:0]       d_req_addr,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rdata
);

    localparam logic [STREAK_W-1:0] L_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] r_streak;
    pend_t               r_pend;

    logic [29:0]         w_i_word;
    logic [29:0]         w_d_word;
    logic                w_i_inrange;
    logic                w_d_inrange;
    logic                w_d_misal;
    logic                w_gnt_d;
    logic                w_gnt_i;
    logic                w_rom_en;
    logic                w_unused;

    assign w_i_word    = i_req_addr[31:2];
    assign w_d_word    = d_req_addr[31:2];
    assign w_i_inrange = word_in_range(w_i_word, ROM_DEPTH);
    assign w_d_inrange = word_in_range(w_d_word, ROM_DEPTH);
    assign w_d_misal   = |d_req_addr[1:0];
    // Fetch ignores the byte offset entirely.
    assign w_unused    = &{1'b0, i_req_addr[1:0]};

    // Data yields only when a fetch is waiting and the streak is exhausted.
    assign w_gnt_d = d_req_valid && !(i_req_valid && (r_streak == L_MAX));
    assign w_gnt_i = i_req_valid && !w_gnt_d;

    assign w_rom_en = (w_gnt_i && w_i_inrange) ||
                      (w_gnt_d && !w_d_misal && w_d_inrange);

    // Handshake and ROM strobes are combinational, so hold them low in reset.
    assign i_req_ready = rst_n && w_gnt_i;
    assign d_req_ready = rst_n && w_gnt_d;
    assign rom_en      = rst_n && w_rom_en;
    assign rom_addr    = !(rst_n && w_rom_en) ? '0 :
                         w_gnt_d ? w_d_word[ADDR_W-1:0] : w_i_word[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
            r_pend   <= '{owner: OWN_NONE, oob: 1'b0, err: 1'b0};
        end else begin
            // Streak only counts data grants that actually made a fetch wait.
            if (!i_req_valid || w_gnt_i)
                r_streak <= '0;
            else if (w_gnt_d && r_streak < L_MAX)
                r_streak <= r_streak + 1'b1;

            if (w_gnt_d)
                r_pend <= '{owner: OWN_DATA, oob: !w_d_misal && !w_d_inrange, err: w_d_misal};
            else if (w_gnt_i)
                r_pend <= '{owner: OWN_INST, oob: !w_i_inrange, err: 1'b0};
            else
                r_pend <= '{owner: OWN_NONE, oob: 1'b0, err: 1'b0};
        end
    end

    // Response mux: the pending record decides between ROM data and constants;
    // the port that does not own the response sees zero.
    always_comb begin
        i_rsp_valid = (r_pend.owner == OWN_INST);
        d_rsp_valid = (r_pend.owner == OWN_DATA);
        i_rsp_data  = '0;
        d_rsp_data  = '0;
        d_rsp_err   = 1'b0;
        if (i_rsp_valid)
            i_rsp_data = r_pend.oob ? NOP_INST : rom_rdata;
        if (d_rsp_valid) begin
            d_rsp_err = r_pend.err;
            if (r_pend.err)
                d_rsp_data = '0;
            else if (r_pend.oob)
                d_rsp_data = DATA_OOB_VALUE;
            else
                d_rsp_data = rom_rdata;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;
    localparam int DEPTH = 16384;
    localparam int AW    = 14;
    localparam int MAXS  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid = 1'b0, d_req_valid = 1'b0;
    logic [31:0]   i_req_addr = '0, d_req_addr = '0;
    logic          i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, d_rsp_err, rom_en;
    logic [31:0]   i_rsp_data, d_rsp_data;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_rdata = '0;

    int total = 0, bad = 0;

    rom_port_arbiter #(.ROM_DEPTH(DEPTH), .ADDR_W(AW), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
    );

    always #5 clk = ~clk;

    // ROM contents are a fixed scramble of the word index.
    function automatic logic [31:0] romf(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) if (rom_en) rom_rdata <= romf(32'(rom_addr));

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h4;
        d_req_valid = 1'b1; d_req_addr = 32'h8;
        @(negedge clk);
        total++;
        if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, d_rsp_err, rom_en} !== 6'b0 ||
            i_rsp_data !== 32'h0 || d_rsp_data !== 32'h0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b%b rv=%b%b err=%b en=%b addr=%h id=%h dd=%h, need all 0",
                     i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, d_rsp_err, rom_en, rom_addr, i_rsp_data, d_rsp_data);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        next_cycle(); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        logic [31:0] prev;
        for (int k = 0; k <= 3; k++) begin
            i_req_valid = (k < 3); i_req_addr = 32'(k * 4);
            @(negedge clk);
            if (k < 3) begin
                total++;
                if (i_req_ready !== 1'b1 || rom_en !== 1'b1 || rom_addr !== AW'(k)) begin
                    bad++;
                    $display("FAIL fetch_accept%0d: rdy=%b en=%b addr=%0d need 1 1 %0d", k, i_req_ready, rom_en, rom_addr, k);
                end
            end
            if (k > 0) begin
                prev = romf(32'(k - 1));
                total++;
                if (i_rsp_valid !== 1'b1 || i_rsp_data !== prev) begin
                    bad++;
                    $display("FAIL fetch_rsp%0d: valid=%b data=%h need 1 %h", k - 1, i_rsp_valid, i_rsp_data, prev);
                end
            end
            next_cycle();
        end
        i_req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch_bounds();
        // last in-range word, then first out-of-range word
        i_req_valid = 1'b1; i_req_addr = 32'h0000_FFFC;
        @(negedge clk);
        total++;
        if (rom_en !== 1'b1 || rom_addr !== AW'(DEPTH - 1)) begin
            bad++; $display("FAIL fetch_last_word: en=%b addr=%h need 1 %h", rom_en, rom_addr, AW'(DEPTH - 1));
        end
        next_cycle(); i_req_addr = 32'h0001_0000;
        @(negedge clk);
        total++;
        if (i_req_ready !== 1'b1 || rom_en !== 1'b0 || rom_addr !== '0) begin
            bad++; $display("FAIL fetch_oob_req: rdy=%b en=%b addr=%h need 1 0 0", i_req_ready, rom_en, rom_addr);
        end
        total++;
        if (i_rsp_valid !== 1'b1 || i_rsp_data !== romf(DEPTH - 1)) begin
            bad++; $display("FAIL fetch_last_rsp: v=%b data=%h need 1 %h", i_rsp_valid, i_rsp_data, romf(DEPTH - 1));
        end
        next_cycle(); i_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h13) begin
            bad++; $display("FAIL fetch_oob_rsp: v=%b data=%h need 1 00000013", i_rsp_valid, i_rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_data_errors();
        d_req_valid = 1'b1; d_req_addr = 32'h102;
        @(negedge clk);
        total++;
        if (d_req_ready !== 1'b1 || rom_en !== 1'b0) begin
            bad++; $display("FAIL data_misal_req: rdy=%b en=%b need 1 0", d_req_ready, rom_en);
        end
        next_cycle(); d_req_addr = 32'h2_0000;
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_data !== 32'h0 || i_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL data_misal_rsp: v=%b err=%b data=%h iv=%b need 1 1 0 0", d_rsp_valid, d_rsp_err, d_rsp_data, i_rsp_valid);
        end
        total++;
        if (rom_en !== 1'b0) begin
            bad++; $display("FAIL data_oob_req: en=%b need 0", rom_en);
        end
        next_cycle(); d_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0 || d_rsp_data !== 32'h0) begin
            bad++; $display("FAIL data_oob_rsp: v=%b err=%b data=%h need 1 0 0", d_rsp_valid, d_rsp_err, d_rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        i_req_valid = 1'b1; i_req_addr = 32'h40;
        d_req_valid = 1'b1; d_req_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (d_req_ready !== (k % 5 != 4) || i_req_ready !== (k % 5 == 4)) begin
                bad++; $display("FAIL contention_grant%0d: d_rdy=%b i_rdy=%b need %b %b", k, d_req_ready, i_req_ready, k % 5 != 4, k % 5 == 4);
            end
            total++;
            if (int'(dut.r_streak) != k % 5) begin
                bad++; $display("FAIL contention_streak%0d: got %0d need %0d", k, dut.r_streak, k % 5);
            end
            next_cycle();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_midop();
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        next_cycle();                          // accepted in previous cycle
        i_req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({i_rsp_valid, d_rsp_valid, rom_en, i_req_ready, d_req_ready} !== 5'b0 || i_rsp_data !== 32'h0) begin
            bad++; $display("FAIL midop_reset: iv=%b dv=%b en=%b data=%h need all 0", i_rsp_valid, d_rsp_valid, rom_en, i_rsp_data);
        end
        next_cycle(); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midop_no_rsp: iv=%b dv=%b need 0 0", i_rsp_valid, d_rsp_valid);
        end
        next_cycle(); i_req_valid = 1'b1;
        next_cycle(); i_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (i_rsp_valid !== 1'b1 || i_rsp_data !== romf(0)) begin
            bad++; $display("FAIL midop_refetch: v=%b data=%h need 1 %h", i_rsp_valid, i_rsp_data, romf(0));
        end
        next_cycle();
    endtask

    // Random traffic against a queue-free reference: the model remembers how
    // many data grants a waiting fetch has sat through and what each accepted
    // address must return.
    task automatic test_random();
        int          waits = 0;
        logic        e_iv = 0, e_dv = 0, e_err = 0, gi, gd, e_en;
        logic [31:0] e_id = '0, e_dd = '0;
        logic [31:0] iw, dw;
        logic [AW-1:0] e_addr;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            total++;
            if (i_rsp_valid !== e_iv || i_rsp_data !== (e_iv ? e_id : 32'h0) ||
                d_rsp_valid !== e_dv || d_rsp_data !== (e_dv ? e_dd : 32'h0) || d_rsp_err !== (e_dv && e_err)) begin
                bad++;
                $display("FAIL rand_rsp c%0d: iv=%b id=%h dv=%b dd=%h err=%b need %b %h %b %h %b", c,
                         i_rsp_valid, i_rsp_data, d_rsp_valid, d_rsp_data, d_rsp_err,
                         e_iv, e_iv ? e_id : 32'h0, e_dv, e_dv ? e_dd : 32'h0, e_dv && e_err);
            end
            iw = {2'b0, i_req_addr[31:2]};
            dw = {2'b0, d_req_addr[31:2]};
            gd = d_req_valid && !(i_req_valid && waits >= MAXS);
            gi = i_req_valid && !gd;
            e_en = (gi && iw < DEPTH) || (gd && d_req_addr[1:0] == 2'b0 && dw < DEPTH);
            e_addr = e_en ? (gd ? AW'(dw) : AW'(iw)) : '0;
            total++;
            if (i_req_ready !== gi || d_req_ready !== gd || rom_en !== e_en || rom_addr !== e_addr) begin
                bad++;
                $display("FAIL rand_grant c%0d: rdy=%b%b en=%b addr=%h need %b%b %b %h", c,
                         i_req_ready, d_req_ready, rom_en, rom_addr, gi, gd, e_en, e_addr);
            end
            e_iv = gi; e_dv = gd;
            e_id = (iw < DEPTH) ? romf(iw) : 32'h13;
            e_err = (d_req_addr[1:0] != 2'b0);
            e_dd = (e_err || dw >= DEPTH) ? 32'h0 : romf(dw);
            if (!i_req_valid || gi) waits = 0;
            else if (gd) waits++;
            next_cycle();
            if (!i_req_valid || gi) begin
                i_req_valid = ($urandom % 4) != 0;
                if ($urandom % 8 == 0) i_req_addr = 32'h1_0000 + ($urandom % 64) * 4 + ($urandom % 4);
                else i_req_addr = ($urandom % DEPTH) * 4 + ($urandom % 4);
            end
            if (!d_req_valid || gd) begin
                d_req_valid = ($urandom % 3) != 0;
                case ($urandom % 8)
                    0: d_req_addr = ($urandom % DEPTH) * 4 + 1 + ($urandom % 3);
                    1: d_req_addr = {$urandom | 32'h0001_0000} & 32'hFFFF_FFFC;
                    default: d_req_addr = ($urandom % DEPTH) * 4;
                endcase
            end
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        next_cycle(); next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_fetch_bounds();
        test_data_errors();
        test_contention();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
